// File: rtl/seg_display_pkg.sv
// seg_display_pkg: shared segment constants, decode table and scheduler state type.
package seg_display_pkg;
  localparam logic [7:0] SEG_BLANK = 8'h7F;
  localparam logic [7:0] SEG_TABLE [16] = '{
    8'h40, 8'h79, 8'h24, 8'h30, 8'h19, 8'h12, 8'h02, 8'h78,
    8'h00, 8'h18, 8'h08, 8'h03, 8'h46, 8'h21, 8'h06, 8'h0E
  };
  typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;
endpackage

// File: rtl/hex_seg_decoder.sv
// hex_seg_decoder: combinational nibble to active-low 7-segment pattern, bit7 always 0.
module hex_seg_decoder
  import seg_display_pkg::*;
(
  input  logic [3:0] nib,
  output logic [7:0] seg
);
  assign seg = SEG_TABLE[nib];
endmodule

// File: rtl/hex_display_scheduler.sv
// hex_display_scheduler: time-shares one decoder over NUM_DIGITS displays, MSB first,
// committing all digits at once, with optional leading-zero blanking and blink gating.
module hex_display_scheduler
  import seg_display_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int BLINK_DIV  = 25000000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  input  logic                    lz_blank_en,
  input  logic                    blink_en,
  output logic [8*NUM_DIGITS-1:0] hex_o,
  output logic                    update_done
);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam int CW = $clog2(BLINK_DIV);
  state_t state, state_d;
  logic [IW-1:0] idx;
  logic seen_nz, lz_q, blink_off, blank_digit;
  logic [CW-1:0] blink_cnt;
  logic [3:0] nibs [NUM_DIGITS];
  logic [7:0] shadow [NUM_DIGITS];
  logic [7:0] disp [NUM_DIGITS];
  logic [3:0] nib;
  logic [7:0] seg;
  assign nib = nibs[idx];
  hex_seg_decoder u_dec (.nib(nib), .seg(seg));
  always_ff @(posedge clk)
    state <= !rst_n ? IDLE : state_d;
  always_comb
    state_d = state == IDLE ? (load_valid ? SCAN : IDLE) :
              state == SCAN ? (idx == '0 ? COMMIT : SCAN) : IDLE;
  always_comb begin
    load_ready  = state == IDLE;
    update_done = state == COMMIT;
  end
  // Digit 0 is never blanked so an all-zero value still shows a single "0".
  assign blank_digit = lz_q && !seen_nz && nib == 4'h0 && idx != '0;
  always_ff @(posedge clk)
    if (!rst_n) begin
      idx     <= '0;
      seen_nz <= 1'b0;
      lz_q    <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        nibs[i]   <= 4'h0;
        shadow[i] <= SEG_BLANK;
        disp[i]   <= SEG_BLANK;
      end
    end else begin
      if (load_valid && load_ready) begin
        for (int i = 0; i < NUM_DIGITS; i++) nibs[i] <= load_data[4*i +: 4];
        lz_q    <= lz_blank_en;
        idx     <= IW'(NUM_DIGITS - 1);
        seen_nz <= 1'b0;
      end
      if (state == SCAN) begin
        shadow[idx] <= blank_digit ? SEG_BLANK : seg;
        seen_nz     <= seen_nz | (nib != 4'h0);
        idx         <= idx - 1'b1;
      end
      if (state == COMMIT) disp <= shadow;
    end
  always_ff @(posedge clk)
    if (!rst_n || !blink_en) begin
      blink_cnt <= '0;
      blink_off <= 1'b0;
    end else if (blink_cnt == CW'(BLINK_DIV - 1)) begin
      blink_cnt <= '0;
      blink_off <= ~blink_off;
    end else
      blink_cnt <= blink_cnt + 1'b1;
  for (genvar g = 0; g < NUM_DIGITS; g++)
    assign hex_o[8*g +: 8] = blink_off ? SEG_BLANK : disp[g];
endmodule

// File: tb/tb_hex_display_scheduler.sv
// tb_hex_display_scheduler: directed bench with a scoreboard of expected display words.
module tb_hex_display_scheduler;
  logic clk = 0, rst_n = 0, load_valid = 0, lz_blank_en = 0, blink_en = 0;
  logic [23:0] load_data = '0;
  logic load_ready, update_done;
  logic [47:0] hex_o;
  logic [47:0] sb [$];
  int tests = 0, fails = 0;
  localparam logic [7:0] TBL [16] = '{8'h40, 8'h79, 8'h24, 8'h30, 8'h19, 8'h12, 8'h02, 8'h78,
                                      8'h00, 8'h18, 8'h08, 8'h03, 8'h46, 8'h21, 8'h06, 8'h0E};
  hex_display_scheduler #(.NUM_DIGITS(6), .BLINK_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .lz_blank_en(lz_blank_en), .blink_en(blink_en),
    .hex_o(hex_o), .update_done(update_done));
  always #5 clk = ~clk;
  function automatic logic [47:0] model(input logic [23:0] d, input logic lz);
    logic [47:0] r = '0;
    logic nz = 1'b0;
    for (int i = 5; i >= 0; i--) begin
      logic [3:0] n = d[4*i +: 4];
      r[8*i +: 8] = (lz && !nz && n == 4'h0 && i != 0) ? 8'h7F : TBL[n];
      nz = nz | (n != 4'h0);
    end
    return r;
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic load(input logic [23:0] d, input logic lz);
    load_valid = 1; load_data = d; lz_blank_en = lz;
    sb.push_back(model(d, lz));
    tick();
    load_valid = 0;
  endtask
  task automatic wait_done(output int n);
    n = 0;
    while (!update_done && n < 20) begin
      tick();
      n++;
    end
  endtask
  task automatic finish_load(input string tag);
    int n;
    wait_done(n);
    check({tag, "_done_cycle"}, 48'(n + 1), 48'd7);
    tick();
    check({tag, "_hex"}, hex_o, sb.pop_front());
  endtask
  initial begin
    int n, hi, pulses;
    repeat (2) tick();
    check("rst_hex", hex_o, {6{8'h7F}});
    check("rst_ready", 48'(load_ready), 48'd1);
    check("rst_done", 48'(update_done), 48'd0);
    rst_n = 1;
    tick();
    load(24'h12AB3F, 0);
    finish_load("load_12AB3F");
    check("load_12AB3F_lit", hex_o, 48'h79_24_08_03_30_0E);
    load(24'h000405, 1);
    finish_load("lz_000405");
    check("lz_000405_lit", hex_o, 48'h7F_7F_7F_19_40_12);
    load(24'h000000, 1);
    finish_load("lz_zero");
    check("lz_zero_lit", hex_o, 48'h7F_7F_7F_7F_7F_40);
    load_valid = 1; load_data = 24'h111111; lz_blank_en = 0;
    sb.push_back(model(24'h111111, 0));
    tick();
    load_data = 24'h222222;
    hi = 0; n = 1;
    while (!update_done && n < 20) begin
      hi += int'(load_ready);
      tick();
      n++;
    end
    hi += int'(load_ready);
    check("busy_ready_high_cycles", 48'(hi), 48'd0);
    check("busy_done_cycle", 48'(n), 48'd7);
    tick();
    check("b2b_first_hex", hex_o, sb.pop_front());
    check("b2b_ready_c8", 48'(load_ready), 48'd1);
    sb.push_back(model(24'h222222, 0));
    tick();
    load_valid = 0;
    wait_done(n);
    check("b2b_second_done_cycle", 48'(n + 9), 48'd15);
    tick();
    check("b2b_second_hex", hex_o, sb.pop_front());
    load(24'hABCDEF, 0);
    tick(); tick();
    rst_n = 0;
    sb.pop_back();
    tick();
    rst_n = 1;
    check("midrst_hex", hex_o, {6{8'h7F}});
    check("midrst_ready", 48'(load_ready), 48'd1);
    pulses = int'(update_done);
    repeat (10) begin
      tick();
      pulses += int'(update_done);
    end
    check("midrst_no_done", 48'(pulses), 48'd0);
    load(24'h000001, 1);
    finish_load("blink_setup");
    blink_en = 1;
    for (int k = 0; k < 16; k++) begin
      check($sformatf("blink_k%0d", k), 48'(hex_o[7:0]), ((k / 4) % 2) ? 48'h7F : 48'h79);
      tick();
    end
    repeat (4) tick();
    check("blink_off_phase", 48'(hex_o[7:0]), 48'h7F);
    blink_en = 0;
    tick();
    check("blink_disable_steady", hex_o, 48'h7F_7F_7F_7F_7F_79);
    check("sb_empty", 48'(sb.size()), 48'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
